// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   pipe_state_e : controller FSM states (debug-visible encoding on state_o)
//   REG_ZERO     : architectural zero register number, never a real dependency
//   NOP_INSTR    : bubble instruction loaded by flushed pipe registers
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StLuStall = 2'b01,
    StFreeze  = 2'b10
  } pipe_state_e;

  localparam int unsigned REG_ZERO = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i : clock
//   rst_i : asynchronous active-low reset, clears the count
//   clr_i : synchronous clear, wins over inc_i
//   inc_i : count up by one unless already all-ones
//   cnt_o : current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller.
// Drives enables/flushes of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers: inserts a
// one-cycle bubble on load-use, flushes the three younger stages on a taken branch and
// freezes the whole pipe while data memory is busy. Keeps saturating stall/flush statistics
// and a sticky memory-wait timeout flag.
//   clk_i, rst_i           : clock, asynchronous active-low reset
//   idex_memread_i/rt_i    : load in ID/EX and its destination register
//   ifid_rs_i/rt_i/use_rt_i: source registers of the IF/ID instruction
//   branch_taken_i         : branch resolved taken this cycle
//   mem_busy_i             : data memory not ready
//   *_en_o, *_flush_o      : pipe register enables and synchronous flushes
//   state_o                : FSM state (debug)
//   stall_cnt_o/flush_cnt_o: saturating event statistics
//   timeout_o              : sticky, memory wait reached MAX_WAIT cycles
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_memread_i,
  input  logic [REG_W-1:0] idex_rt_i,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  input  logic             ifid_use_rt_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             idex_en_o,
  output logic             exmem_en_o,
  output logic             memwb_en_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             timeout_o
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  pipe_state_e state_q, state_d;
  logic        timeout_q, timeout_d;
  logic        load_use;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic        stall_inc, flush_inc, wait_inc;
  logic [WAIT_W-1:0] wait_cnt;

  assign load_use = idex_memread_i && (idex_rt_i != REG_W'(REG_ZERO)) &&
                    ((idex_rt_i == ifid_rs_i) || (ifid_use_rt_i && (idex_rt_i == ifid_rt_i)));

  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    wait_inc    = 1'b0;
    case (state_q)
      StRun, StLuStall: begin
        if (mem_busy_i) begin
          state_d = StFreeze;
        end else if (branch_taken_i) begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
          {ifid_flush, idex_flush, exmem_flush}         = '1;
          flush_inc = 1'b1;
          state_d   = StRun;
        end else if ((state_q == StRun) && load_use) begin
          // Hold PC and IF/ID, push a bubble into ID/EX behind the load.
          {idex_en, exmem_en, memwb_en} = '1;
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
          state_d    = StLuStall;
        end else begin
          // Load-use in LU_STALL is ignored: the load has already moved on.
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
          state_d = StRun;
        end
      end
      StFreeze: begin
        if (mem_busy_i) begin
          wait_inc = 1'b1;
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Sets at the end of the MAX_WAIT-th frozen cycle.
  assign timeout_d = timeout_q ||
                     ((state_q == StFreeze) && (wait_cnt >= WAIT_W'(MAX_WAIT - 1)));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StRun;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt_o)
  );

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (!wait_inc),
    .inc_i (wait_inc),
    .cnt_o (wait_cnt)
  );

  // Everything held and nothing flushed while reset is asserted.
  assign pc_en_o       = rst_i && pc_en;
  assign ifid_en_o     = rst_i && ifid_en;
  assign idex_en_o     = rst_i && idex_en;
  assign exmem_en_o    = rst_i && exmem_en;
  assign memwb_en_o    = rst_i && memwb_en;
  assign ifid_flush_o  = rst_i && ifid_flush;
  assign idex_flush_o  = rst_i && idex_flush;
  assign exmem_flush_o = rst_i && exmem_flush;
  assign state_o       = state_q;
  assign timeout_o     = timeout_q;

endmodule
